// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage RV32I pipeline.
// Merges load-use stalls, branch flushes, dmem wait handshakes and debug
// halt/resume into per-stage enables, the execute bubble and the F/D flush.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush event counters.
// A flush arriving while the pipe is frozen (dmem wait or halted) is
// latched and applied on the first cycle the pipe advances again.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  input  logic        halt_req_i,
  input  logic        resume_i,
  output logic        en_fetch_o,
  output logic        en_decode_o,
  output logic        en_excte_o,
  output logic        en_memory_o,
  output logic        bubble_excte_o,
  output logic        flush_fd_o,
  output logic        dmem_abort_o,
  output logic        err_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        halted_o
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_HALTED   = 2'd3;

  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next, wait_inc;
  logic [3:0] drain_cnt_reg, drain_cnt_next;
  logic       pending_reg, pending_next;
  logic       err_reg, err_next;

  logic en_f, en_d, en_e, en_m, bubble, flush_fd, abort, halted;
  logic dwait;

  assign dwait    = dmem_req_i & ~dmem_ready_i;
  assign wait_inc = (wait_cnt_reg == TIMEOUT) ? TIMEOUT : wait_cnt_reg + 8'd1;

  // Next-state and output decode for the four sequencer states.
  always_comb begin
    en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0;
    bubble = 1'b0; flush_fd = 1'b0; abort = 1'b0; halted = 1'b0;
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    pending_next   = pending_reg;
    err_next       = err_reg;
    case (state_reg)
      S_RUN: begin
        if (dwait) begin
          // A redirect in the cycle the access stalls is kept, not lost.
          state_next    = S_MEM_WAIT;
          wait_cnt_next = 8'd1;
          if (flush_i) pending_next = 1'b1;
        end else begin
          {en_f, en_d, en_e, en_m} = 4'hf;
          if (flush_i || pending_reg) begin
            flush_fd     = 1'b1;
            pending_next = 1'b0;
          end else if (stall_i) begin
            en_f   = 1'b0;
            en_d   = 1'b0;
            bubble = 1'b1;
          end
          if (halt_req_i) begin
            en_f           = 1'b0;
            bubble         = 1'b1;
            state_next     = S_DRAIN;
            drain_cnt_next = 4'd0;
            wait_cnt_next  = 8'd0;
          end
        end
      end
      S_MEM_WAIT: begin
        if (flush_i) pending_next = 1'b1;
        if (dmem_ready_i) begin
          {en_f, en_d, en_e, en_m} = 4'hf;
          state_next    = S_RUN;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt_reg == TIMEOUT) begin
          {en_f, en_d, en_e, en_m} = 4'hf;
          abort         = 1'b1;
          err_next      = 1'b1;
          state_next    = S_RUN;
          wait_cnt_next = 8'd0;
        end else begin
          wait_cnt_next = wait_inc;
        end
      end
      S_DRAIN: begin
        if (dwait && wait_cnt_reg != TIMEOUT) begin
          // Frozen on dmem: hold drain progress, latch any redirect.
          if (flush_i) pending_next = 1'b1;
          wait_cnt_next = wait_inc;
        end else begin
          if (dwait) begin
            abort    = 1'b1;
            err_next = 1'b1;
          end
          wait_cnt_next = 8'd0;
          en_d   = 1'b1;
          en_e   = 1'b1;
          en_m   = 1'b1;
          bubble = 1'b1;
          if (flush_i || pending_reg) begin
            flush_fd     = 1'b1;
            pending_next = 1'b0;
          end
          if (drain_cnt_reg == DRAIN_LAST) state_next = S_HALTED;
          else drain_cnt_next = drain_cnt_reg + 4'd1;
        end
      end
      default: begin
        halted = 1'b1;
        if (flush_i) pending_next = 1'b1;
        if (resume_i) state_next = S_RUN;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= S_RUN;
      wait_cnt_reg  <= 8'd0;
      drain_cnt_reg <= 4'd0;
      pending_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      pending_reg   <= pending_next;
      err_reg       <= err_next;
    end
  end

  // Every output is forced low while reset is held.
  assign en_fetch_o     = rstn_i & en_f;
  assign en_decode_o    = rstn_i & en_d;
  assign en_excte_o     = rstn_i & en_e;
  assign en_memory_o    = rstn_i & en_m;
  assign bubble_excte_o = rstn_i & bubble;
  assign flush_fd_o     = rstn_i & flush_fd;
  assign dmem_abort_o   = rstn_i & abort;
  assign err_o          = rstn_i & err_reg;
  assign halted_o       = rstn_i & halted;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  // Event counters: fetch-held cycles outside halt, and flush cycles.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (!en_f && state_reg != S_HALTED) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (flush_fd) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the sequencer.
// Observed vector order: {en_fetch, en_decode, en_excte, en_memory,
//                         bubble, flush_fd, abort, err, halted}.
module tb_pipe_ctrl;
  localparam int MEM_TIMEOUT  = 16;
  localparam int DRAIN_CYCLES = 4;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic stall_i = 1'b0, flush_i = 1'b0, dmem_req_i = 1'b0, dmem_ready_i = 1'b0;
  logic halt_req_i = 1'b0, resume_i = 1'b0;
  logic en_fetch_o, en_decode_o, en_excte_o, en_memory_o;
  logic bubble_excte_o, flush_fd_o, dmem_abort_o, err_o, halted_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
  int m_stalls, m_flushes, n_stalls, n_flushes;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] obs, exp_v;

  pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i),
    .en_fetch_o(en_fetch_o), .en_decode_o(en_decode_o),
    .en_excte_o(en_excte_o), .en_memory_o(en_memory_o),
    .bubble_excte_o(bubble_excte_o), .flush_fd_o(flush_fd_o),
    .dmem_abort_o(dmem_abort_o), .err_o(err_o),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: pipeline condition as independent flags and counts.
  bit m_waiting, m_draining, m_halted, m_pend, m_err;
  int m_waited;   // consecutive unfinished dmem cycles already elapsed
  int m_drained;  // drain cycles completed
  bit n_waiting, n_draining, n_halted, n_pend, n_err;
  int n_waited, n_drained;

  function automatic logic [8:0] sample();
    return {en_fetch_o, en_decode_o, en_excte_o, en_memory_o,
            bubble_excte_o, flush_fd_o, dmem_abort_o, err_o, halted_o};
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_draining = 0; m_halted = 0; m_pend = 0; m_err = 0;
    m_waited = 0; m_drained = 0;
`ifdef PIPE_CTRL_PERF_EN
    m_stalls = 0; m_flushes = 0;
`endif
  endtask

  task automatic model_eval(input bit st, input bit fl, input bit rq, input bit rd,
                            input bit hr, input bit rs, output logic [8:0] e);
    bit f, d, x, m, b, fd, ab, busy;
    f = 0; d = 0; x = 0; m = 0; b = 0; fd = 0; ab = 0;
    busy = rq && !rd;
    n_waiting = m_waiting; n_draining = m_draining; n_halted = m_halted;
    n_pend = m_pend; n_err = m_err; n_waited = m_waited; n_drained = m_drained;
    if (m_halted) begin
      if (fl) n_pend = 1;
      if (rs) n_halted = 0;
    end else if (m_waiting) begin
      if (fl) n_pend = 1;
      if (rd || m_waited == MEM_TIMEOUT) begin
        f = 1; d = 1; x = 1; m = 1;
        n_waiting = 0; n_waited = 0;
        if (!rd) begin ab = 1; n_err = 1; end
      end else n_waited = m_waited + 1;
    end else if (m_draining) begin
      if (busy && m_waited != MEM_TIMEOUT) begin
        if (fl) n_pend = 1;
        n_waited = m_waited + 1;
      end else begin
        if (busy) begin ab = 1; n_err = 1; end
        n_waited = 0;
        d = 1; x = 1; m = 1; b = 1;
        if (fl || m_pend) begin fd = 1; n_pend = 0; end
        if (m_drained + 1 == DRAIN_CYCLES) begin n_draining = 0; n_halted = 1; end
        else n_drained = m_drained + 1;
      end
    end else begin
      if (busy) begin
        n_waiting = 1; n_waited = 1;
        if (fl) n_pend = 1;
      end else begin
        f = 1; d = 1; x = 1; m = 1;
        if (fl || m_pend) begin fd = 1; n_pend = 0; end
        else if (st) begin f = 0; d = 0; b = 1; end
        if (hr) begin f = 0; b = 1; n_draining = 1; n_drained = 0; n_waited = 0; end
      end
    end
    e = {f, d, x, m, b, fd, ab, m_err, m_halted};
`ifdef PIPE_CTRL_PERF_EN
    n_stalls  = m_stalls + ((!f && !m_halted) ? 1 : 0);
    n_flushes = m_flushes + (fd ? 1 : 0);
`endif
  endtask

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
  task automatic cycle(input string tag, input bit st, input bit fl, input bit rq,
                       input bit rd, input bit hr, input bit rs);
    @(negedge clk_i);
    stall_i = st; flush_i = fl; dmem_req_i = rq; dmem_ready_i = rd;
    halt_req_i = hr; resume_i = rs;
    #1;
    model_eval(st, fl, rq, rd, hr, rs, exp_v);
    obs = sample();
    chk(tag, obs, exp_v);
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    assert ({stall_cnt_o, flush_cnt_o} === {32'(m_stalls), 32'(m_flushes)}) else begin
      errors++;
      $error("FAIL %s_perf: observed %0d/%0d expected %0d/%0d", tag,
             stall_cnt_o, flush_cnt_o, m_stalls, m_flushes);
    end
`endif
    @(posedge clk_i);
    m_waiting = n_waiting; m_draining = n_draining; m_halted = n_halted;
    m_pend = n_pend; m_err = n_err; m_waited = n_waited; m_drained = n_drained;
`ifdef PIPE_CTRL_PERF_EN
    m_stalls = n_stalls; m_flushes = n_flushes;
`endif
    #1;
  endtask

  initial begin
    // Reset held with requests asserted: every output low.
    stall_i = 1; flush_i = 1; halt_req_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("in_reset", sample(), 9'b0);
    stall_i = 0; flush_i = 0; halt_req_i = 0;
    model_reset();
    rstn_i = 1;

    cycle("rst_release", 0, 0, 0, 0, 0, 0);
    chk("rst_release_k", obs, 9'b1111_00000);

    cycle("stall", 1, 0, 0, 0, 0, 0);
    chk("stall_k", obs, 9'b0011_10000);
    cycle("after_stall", 0, 0, 0, 0, 0, 0);
    chk("after_stall_k", obs, 9'b1111_00000);

    // dmem wait with a flush mid-wait: redirect deferred to the RUN cycle.
    cycle("mw1", 0, 0, 1, 0, 0, 0);
    chk("mw1_k", obs, 9'b0);
    cycle("mw2", 0, 1, 1, 0, 0, 0);
    chk("mw2_k", obs, 9'b0);
    cycle("mw3", 0, 0, 1, 0, 0, 0);
    chk("mw3_k", obs, 9'b0);
    cycle("mw_rel", 0, 0, 1, 1, 0, 0);
    chk("mw_rel_k", obs, 9'b1111_00000);
    cycle("pend_flush", 0, 0, 0, 0, 0, 0);
    chk("pend_flush_k", obs, 9'b1111_01000);
    cycle("flush_once", 0, 0, 0, 0, 0, 0);
    chk("flush_once_k", obs, 9'b1111_00000);

    // Access that never completes: abort on the cycle the wait count hits limit.
    cycle("to_enter", 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      cycle("to_wait", 0, 0, 1, 0, 0, 0);
      if (i == MEM_TIMEOUT) chk("to_abort_k", obs, 9'b1111_00100);
    end
    cycle("err_sticky", 0, 0, 0, 0, 0, 0);
    chk("err_sticky_k", obs, 9'b1111_00010);

    // Halt: acceptance cycle, DRAIN_CYCLES drain cycles, then halted.
    cycle("halt_acc", 0, 0, 0, 0, 1, 0);
    chk("halt_acc_k", obs, 9'b0111_10010);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      cycle("drain", 0, 0, 0, 0, 1, 0);
      chk("drain_k", obs, 9'b0111_10010);
    end
    cycle("halted", 0, 0, 0, 0, 1, 0);
    chk("halted_k", obs, 9'b0000_00011);
    cycle("resume", 0, 0, 0, 0, 0, 1);
    chk("resume_k", obs, 9'b0000_00011);
    cycle("resumed", 0, 0, 0, 0, 0, 0);
    chk("resumed_k", obs, 9'b1111_00010);

    cycle("stall_flush", 1, 1, 0, 0, 0, 0);
    chk("stall_flush_k", obs, 9'b1111_01010);

    // Reset mid-wait with a latched flush: both discarded.
    cycle("mr1", 0, 0, 1, 0, 0, 0);
    cycle("mr2", 0, 1, 1, 0, 0, 0);
    rstn_i = 0;
    #2;
    chk("mid_reset", sample(), 9'b0);
    stall_i = 0; flush_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
    model_reset();
    rstn_i = 1;
    cycle("post_reset", 0, 0, 0, 0, 0, 0);
    chk("post_reset_k", obs, 9'b1111_00000);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit st, fl, rq, rd, hr, rs;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      rq = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      hr = ((n / 200) % 3 == 1) && ($urandom_range(0, 1) == 0);
      rs = ($urandom_range(0, 7) == 0);
      if ((n / 500) % 2 == 1) rd = ($urandom_range(0, 40) == 0);
      cycle("random", st, fl, rq, rd, hr, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
